// File: rtl/xor_stim_checker.sv
`default_nettype none
// ============================================================================
// Module   : xor_stim_checker
// Brief    : Restartable stimulus sequencer and checker for a 2-input XOR gate.
//            Optional macro XOR_STIM_STOP_ON_ERR_EN ends a run on first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module xor_stim_checker #(
    parameter int HOLD_CYCLES = 4,
    parameter int ROUNDS      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [1:0] fail_vec
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_run     = 2'd1;
    localparam logic [1:0] c_st_fin     = 2'd2;
    localparam logic [7:0] c_hold_last  = 8'(HOLD_CYCLES - 1);
    localparam logic [5:0] c_round_last = 6'(ROUNDS - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [1:0] r_vec;
    logic [7:0] r_hold_cnt;
    logic [5:0] r_round_cnt;
    logic       r_seen_err;
    logic       r_pass;
    logic [7:0] r_err_cnt;
    logic [1:0] r_fail_vec;

    logic       w_end_hold;
    logic       w_mismatch;
    logic       w_last_vec;
    logic       w_finish;
    logic [7:0] w_err_next;

    // y is only consulted on the final edge of each hold window
    assign w_end_hold = (r_state == c_st_run) && (r_hold_cnt == c_hold_last);
    assign w_mismatch = w_end_hold && (y != (r_vec[1] ^ r_vec[0]));
    assign w_last_vec = (r_vec == 2'd3) && (r_round_cnt == c_round_last);
    assign w_err_next = (w_mismatch && (r_err_cnt != 8'hFF)) ? r_err_cnt + 8'd1 : r_err_cnt;

`ifdef XOR_STIM_STOP_ON_ERR_EN
    assign w_finish = w_end_hold && (w_last_vec || w_mismatch);
`else
    assign w_finish = w_end_hold && w_last_vec;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (start) w_state_next = c_st_run;
            c_st_run:  if (w_finish) w_state_next = c_st_fin;
            c_st_fin:  w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec       <= 2'd0;
            r_hold_cnt  <= 8'd0;
            r_round_cnt <= 6'd0;
            r_seen_err  <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= 8'd0;
            r_fail_vec  <= 2'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_vec       <= 2'd0;
                        r_hold_cnt  <= 8'd0;
                        r_round_cnt <= 6'd0;
                        r_seen_err  <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err_cnt   <= 8'd0;
                        r_fail_vec  <= 2'd0;
                    end
                end
                c_st_run: begin
                    if (w_end_hold) begin
                        r_hold_cnt <= 8'd0;
                        r_err_cnt  <= w_err_next;
                        if (w_mismatch && !r_seen_err) begin
                            r_fail_vec <= r_vec;
                            r_seen_err <= 1'b1;
                        end
                        if (w_finish) begin
                            r_vec  <= 2'd0;
                            r_pass <= (w_err_next == 8'd0);
                        end else begin
                            r_vec <= r_vec + 2'd1;
                            if (r_vec == 2'd3) r_round_cnt <= r_round_cnt + 6'd1;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // r_vec is forced to 0 outside RUN, so a/b come straight from flops
    assign a        = r_vec[1];
    assign b        = r_vec[0];
    assign busy     = (r_state == c_st_run);
    assign done     = (r_state == c_st_fin);
    assign pass     = r_pass;
    assign err_cnt  = r_err_cnt;
    assign fail_vec = r_fail_vec;

endmodule
`default_nettype wire
